regfile_ctrl: RTL and testbench
===============================

REGFILE_CTRL -- requirements
Module: regfile_ctrl

Interface
REQ-001 SHALL have clk, input, 1, single clock; all state changes on its rising edge.
REQ-002 SHALL have rst, input, 1, asynchronous active-low reset.
REQ-003 SHALL have pipe_we/pipe_waddr/pipe_wdata, input, 1/5/32, pipeline writeback request.
REQ-004 SHALL have host_req/host_waddr/host_wdata, input, 1/5/32, host write request, held until ack.
REQ-005 SHALL have host_ack, output, 1, write-done pulse.
REQ-006 SHALL have clr_start, input, 1, start clear sequence.
REQ-007 SHALL have rf_we/rf_waddr/rf_wdata, output, 1/5/32, to the register-file write port.
REQ-008 SHALL have stall_req, output, 1, pipeline stall request.
REQ-009 SHALL have busy and wr_drop, output, 1 each: sequencer active; sticky dropped-pipe-write flag.
REQ-010 SHALL have dump ports, present only with RF_DUMP_EN: dump_start in 1; rf_select out 5; rf_sel_data in 32; dump_valid out 1; dump_ready in 1; dump_addr out 5; dump_data out 32.

Function
REQ-011 SHALL implement FSM states IDLE, CLEAR, DUMP_RD, DUMP_OUT; one 5-bit index counter idx.
REQ-012 SHALL drive rf_* combinationally; pipe path zero-latency so register-file bypass timing is preserved.
REQ-013 SHALL, in IDLE/DUMP_*, pass the pipe write when pipe_we=1; host write only in cycles with pipe_we=0.
REQ-014 SHALL, on a host write cycle, drive rf_we=1 and host_* onto rf_*, and pulse host_ack=1 in that same cycle.
REQ-015 SHALL, for host_waddr=0, pulse host_ack but hold rf_we=0.
REQ-016 SHALL count consecutive cycles with host_req=1 and pipe_we=1 (3-bit, saturating); at count 4 assert stall_req from next cycle until the host_ack cycle; counter clears on host_ack.
REQ-017 SHALL, in CLEAR, drive rf_we=1, rf_waddr=idx, rf_wdata=0, idx stepping 1..31, one register per cycle; 31 cycles total; leave to IDLE after idx=31.
REQ-018 SHALL, in CLEAR, hold stall_req=1 and busy=1; ignore host_req (no ack); ignore pipe_we and set wr_drop=1 if pipe_we=1.
REQ-019 SHALL clear wr_drop only on reset.
REQ-020 SHALL accept clr_start only in IDLE; clr_start takes priority over dump_start in the same cycle.
REQ-021 SHALL ignore clr_start and dump_start outside IDLE.

Reset
REQ-022 SHALL, while rst=0, force state IDLE, idx=0, all outputs 0, stall counter 0, wr_drop 0.
REQ-023 SHALL, on the first clock after rst deasserts, enter CLEAR automatically (idx=1).
REQ-024 SHALL, on reset mid-CLEAR or mid-DUMP, abandon the sequence immediately; no completion handshake.

Configuration
REQ-025 SHALL compile the dump sequencer and its ports only when RF_DUMP_EN is defined.
REQ-026 SHALL, with RF_DUMP_EN, accept dump_start in IDLE: idx=0, DUMP_RD, rf_select=idx, regfile read data available one cycle later.
REQ-027 SHALL, in DUMP_RD, capture rf_sel_data into dump_data one cycle after select, forcing 0 when idx=0; set dump_addr=idx, then move to DUMP_OUT.
REQ-028 SHALL, in DUMP_OUT, hold dump_valid=1 and stable dump_addr/dump_data until dump_ready=1; on handshake step idx and return to DUMP_RD, or to IDLE after idx=31.
REQ-029 SHALL keep pipe and host writes serviced during DUMP_* with busy=1 and stall_req only per REQ-016.
REQ-030 SHALL, without RF_DUMP_EN, omit dump ports and states; dump_start does not exist, and the FSM has IDLE/CLEAR only.

Verification
REQ-031 SHALL check: release reset -> 31 cycles rf_we=1, rf_waddr 1..31, rf_wdata=0, stall_req=1, busy=1; then IDLE, busy=0.
REQ-032 SHALL check: IDLE, host_req waddr=5 data=0xDEADBEEF, pipe_we=0 -> same-cycle rf_we=1 waddr=5 host_ack=1.
REQ-033 SHALL check: host_req held with pipe_we=1 every cycle -> stall_req=1 from cycle 5; first pipe_we=0 cycle -> host write+ack; stall_req=0 next cycle.
REQ-034 SHALL check: pipe_we=1 during CLEAR -> write not on rf_*; wr_drop=1 until reset.
REQ-035 SHALL check: host_req waddr=0 -> host_ack=1, rf_we=0.
REQ-036 SHALL check (RF_DUMP_EN): reg3=0x12345678, dump_start, dump_ready stuck 0 for 10 cycles at idx 3 -> dump_valid=1 stable, dump_addr=3, dump_data=0x12345678; 32 handshakes total, idx0 data=0.

Source files
------------

// File: rtl/regfile_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_ctrl
//  Description : Write-port arbiter and sequencer for a 32x32 register file.
//                Merges pipeline writeback (zero latency, highest priority)
//                with a held host write request. Runs a clear sequence that
//                zeroes r1..r31 after reset or on request, and (optionally)
//                a dump sequence that streams every register out over a
//                valid/ready handshake.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Optional feature macro: RF_DUMP_EN (dump sequencer, DUMP_* states, ports)
// ----------------------------------------------------------------------------
//  Ports
//    clk                       : clock, rising edge
//    rst                       : asynchronous reset, active low
//    pipe_we/waddr/wdata       : pipeline writeback request
//    host_req/waddr/wdata      : host write request, held until host_ack
//    host_ack                  : host write done (same cycle as the write)
//    clr_start                 : start a clear sequence (accepted in IDLE)
//    rf_we/rf_waddr/rf_wdata   : register-file write port
//    stall_req                 : pipeline stall request
//    busy                      : a sequence (clear/dump) is running
//    wr_drop                   : sticky, a pipe write was dropped in CLEAR
//    dump_start     (dump)     : start a dump sequence (accepted in IDLE)
//    rf_select      (dump)     : register-file read select
//    rf_sel_data    (dump)     : read data, valid one cycle after rf_select
//    dump_valid/ready (dump)   : dump output handshake
//    dump_addr/data (dump)     : dumped register index and value
// ============================================================================
module regfile_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        pipe_we,
    input  logic [4:0]  pipe_waddr,
    input  logic [31:0] pipe_wdata,
    input  logic        host_req,
    input  logic [4:0]  host_waddr,
    input  logic [31:0] host_wdata,
    output logic        host_ack,
    input  logic        clr_start,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        stall_req,
    output logic        busy,
    output logic        wr_drop
`ifdef RF_DUMP_EN
    ,
    input  logic        dump_start,
    output logic [4:0]  rf_select,
    input  logic [31:0] rf_sel_data,
    output logic        dump_valid,
    input  logic        dump_ready,
    output logic [4:0]  dump_addr,
    output logic [31:0] dump_data
`endif
);

    localparam logic [4:0] C_LAST_IDX = 5'd31;

`ifdef RF_DUMP_EN
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CLEAR    = 2'd1,
        ST_DUMP_RD  = 2'd2,
        ST_DUMP_OUT = 2'd3
    } state_t;
`else
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;
`endif

    state_t      r_state;
    state_t      w_next_state;
    logic [4:0]  r_idx;
    logic [4:0]  w_next_idx;
    logic        r_init;        // first cycle after reset release
    logic [2:0]  r_stall_cnt;
    logic        r_wr_drop;

    logic        w_service;     // state in which pipe/host writes are serviced
    logic        w_rf_we;
    logic [4:0]  w_rf_waddr;
    logic [31:0] w_rf_wdata;
    logic        w_host_ack;

`ifdef RF_DUMP_EN
    logic        r_rd_phase;    // 0: select presented, 1: read data valid
    logic [4:0]  r_dump_addr;
    logic [31:0] r_dump_data;
`endif

    // ------------------------------------------------------------------
    // Next-state, index and write-port selection
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_next_idx   = r_idx;
        w_service    = 1'b0;
        w_rf_we      = 1'b0;
        w_rf_waddr   = 5'd0;
        w_rf_wdata   = 32'd0;
        w_host_ack   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_service = 1'b1;
                // The clear after reset is started from IDLE on the first
                // clock, so reset itself leaves the FSM in a plain IDLE.
                if (r_init || clr_start) begin
                    w_next_state = ST_CLEAR;
                    w_next_idx   = 5'd1;
                end
`ifdef RF_DUMP_EN
                else if (dump_start) begin
                    w_next_state = ST_DUMP_RD;
                    w_next_idx   = 5'd0;
                end
`endif
            end

            ST_CLEAR: begin
                w_rf_we    = 1'b1;
                w_rf_waddr = r_idx;
                w_rf_wdata = 32'd0;
                if (r_idx == C_LAST_IDX) begin
                    w_next_state = ST_IDLE;
                    w_next_idx   = 5'd0;
                end else begin
                    w_next_idx = r_idx + 5'd1;
                end
            end

`ifdef RF_DUMP_EN
            ST_DUMP_RD: begin
                w_service = 1'b1;
                if (r_rd_phase) begin
                    w_next_state = ST_DUMP_OUT;
                end
            end

            ST_DUMP_OUT: begin
                w_service = 1'b1;
                if (dump_ready) begin
                    if (r_idx == C_LAST_IDX) begin
                        w_next_state = ST_IDLE;
                        w_next_idx   = 5'd0;
                    end else begin
                        w_next_state = ST_DUMP_RD;
                        w_next_idx   = r_idx + 5'd1;
                    end
                end
            end
`endif

            default: begin
                w_next_state = ST_IDLE;
                w_next_idx   = 5'd0;
            end
        endcase

        // Pipe writeback always wins; the host only gets free cycles.
        // The host is not acked in the release cycle, since the clear that
        // follows would overwrite its register.
        if (w_service) begin
            if (pipe_we) begin
                w_rf_we    = 1'b1;
                w_rf_waddr = pipe_waddr;
                w_rf_wdata = pipe_wdata;
            end else if (host_req && !r_init) begin
                w_host_ack = 1'b1;
                w_rf_we    = (host_waddr != 5'd0);   // r0 is hardwired zero
                w_rf_waddr = host_waddr;
                w_rf_wdata = host_wdata;
            end
        end
    end

    // ------------------------------------------------------------------
    // State, index, starvation counter, dropped-write flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_idx       <= 5'd0;
            r_init      <= 1'b1;
            r_stall_cnt <= 3'd0;
            r_wr_drop   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_idx   <= w_next_idx;
            r_init  <= 1'b0;

            // Counts consecutive cycles where the host lost to the pipe.
            if (r_state == ST_CLEAR || w_host_ack) begin
                r_stall_cnt <= 3'd0;
            end else if (w_service && host_req && pipe_we) begin
                if (r_stall_cnt != 3'd7) begin
                    r_stall_cnt <= r_stall_cnt + 3'd1;
                end
            end else begin
                r_stall_cnt <= 3'd0;
            end

            if (r_state == ST_CLEAR && pipe_we) begin
                r_wr_drop <= 1'b1;
            end
        end
    end

`ifdef RF_DUMP_EN
    // ------------------------------------------------------------------
    // Dump capture: the register file reads synchronously, so DUMP_RD
    // spends one cycle presenting the select and captures on the next.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_phase  <= 1'b0;
            r_dump_addr <= 5'd0;
            r_dump_data <= 32'd0;
        end else if (r_state == ST_DUMP_RD) begin
            if (r_rd_phase) begin
                r_rd_phase  <= 1'b0;
                r_dump_addr <= r_idx;
                r_dump_data <= (r_idx == 5'd0) ? 32'd0 : rf_sel_data;
            end else begin
                r_rd_phase <= 1'b1;
            end
        end else begin
            r_rd_phase <= 1'b0;
        end
    end

    assign rf_select  = r_idx;
    assign dump_valid = (r_state == ST_DUMP_OUT);
    assign dump_addr  = r_dump_addr;
    assign dump_data  = r_dump_data;
`endif

    // ------------------------------------------------------------------
    // Outputs. The write port and ack are combinational from the request
    // inputs, so they are gated by reset to stay quiet while it is held.
    // ------------------------------------------------------------------
    assign rf_we     = rst & w_rf_we;
    assign rf_waddr  = rst ? w_rf_waddr : 5'd0;
    assign rf_wdata  = rst ? w_rf_wdata : 32'd0;
    assign host_ack  = rst & w_host_ack;
    assign stall_req = (r_state == ST_CLEAR) | r_stall_cnt[2];
    assign busy      = (r_state != ST_IDLE);
    assign wr_drop   = r_wr_drop;

endmodule
`default_nettype wire

// File: tb/tb_regfile_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_ctrl
//  Description : Directed self-checking bench for regfile_ctrl. Inputs change
//                1 ns after a rising edge, outputs are sampled 2 ns after it.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_ctrl;

    logic        clk;
    logic        rst;
    logic        pipe_we;
    logic [4:0]  pipe_waddr;
    logic [31:0] pipe_wdata;
    logic        host_req;
    logic [4:0]  host_waddr;
    logic [31:0] host_wdata;
    logic        host_ack;
    logic        clr_start;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        stall_req;
    logic        busy;
    logic        wr_drop;
`ifdef RF_DUMP_EN
    logic        dump_start;
    logic [4:0]  rf_select;
    logic [31:0] rf_sel_data;
    logic        dump_valid;
    logic        dump_ready;
    logic [4:0]  dump_addr;
    logic [31:0] dump_data;
    logic [31:0] mem [32];
    logic [31:0] exp_rf [32];
`endif

    int n_checks;
    int n_fail;

    regfile_ctrl u_dut (
        .clk        (clk),
        .rst        (rst),
        .pipe_we    (pipe_we),
        .pipe_waddr (pipe_waddr),
        .pipe_wdata (pipe_wdata),
        .host_req   (host_req),
        .host_waddr (host_waddr),
        .host_wdata (host_wdata),
        .host_ack   (host_ack),
        .clr_start  (clr_start),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .stall_req  (stall_req),
        .busy       (busy),
        .wr_drop    (wr_drop)
`ifdef RF_DUMP_EN
        ,
        .dump_start (dump_start),
        .rf_select  (rf_select),
        .rf_sel_data(rf_sel_data),
        .dump_valid (dump_valid),
        .dump_ready (dump_ready),
        .dump_addr  (dump_addr),
        .dump_data  (dump_data)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef RF_DUMP_EN
    // Register file with synchronous read, written through the DUT port.
    initial begin
        for (int k = 0; k < 32; k++) mem[k] = 32'hFFFF_FFFF;
        rf_sel_data = 32'd0;
    end
    always @(posedge clk) begin
        if (rf_we) mem[rf_waddr] <= rf_wdata;
        rf_sel_data <= mem[rf_select];
    end
`endif

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Checks clear-sequence cycles idx=from..31, then the return to IDLE.
    // A clr_start pulse at idx 5 must be ignored.
    task automatic clear_cycles(input int from);
        for (int i = from; i <= 31; i++) begin
            clr_start = (i == 5);
            #1;
            chk("clr_we",    rf_we,     1);
            chk("clr_waddr", rf_waddr,  i);
            chk("clr_wdata", rf_wdata,  0);
            chk("clr_stall", stall_req, 1);
            chk("clr_busy",  busy,      1);
            next_cycle();
        end
        clr_start = 1'b0;
        #1;
        chk("clr_done_busy",  busy,      0);
        chk("clr_done_stall", stall_req, 0);
        chk("clr_done_we",    rf_we,     0);
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        rst        = 1'b0;
        pipe_we    = 1'b1;
        pipe_waddr = 5'd2;
        pipe_wdata = 32'h0000_0022;
        host_req   = 1'b1;
        host_waddr = 5'd5;
        host_wdata = 32'h0000_0055;
        clr_start  = 1'b0;
`ifdef RF_DUMP_EN
        dump_start = 1'b0;
        dump_ready = 1'b0;
        for (int k = 0; k < 32; k++) exp_rf[k] = 32'd0;
        exp_rf[3] = 32'h1234_5678;
        exp_rf[4] = 32'h0000_0044;
        exp_rf[5] = 32'hDEAD_BEEF;
        exp_rf[9] = 32'h1122_3344;
`endif

        // ---- reset: outputs quiet even with requests present ----
        repeat (2) @(posedge clk);
        #2;
        chk("rst_rf_we",    rf_we,     0);
        chk("rst_host_ack", host_ack,  0);
        chk("rst_stall",    stall_req, 0);
        chk("rst_busy",     busy,      0);
        chk("rst_wr_drop",  wr_drop,   0);
        pipe_we  = 1'b0;
        host_req = 1'b0;

        // ---- release: automatic clear, with dropped pipe write and ignored host ----
        next_cycle();
        rst = 1'b1;
        next_cycle();
        for (int i = 1; i <= 31; i++) begin
            pipe_we    = (i == 10);
            pipe_waddr = 5'd7;
            pipe_wdata = 32'h0000_AAAA;
            host_req   = (i == 12);
            host_waddr = 5'd6;
            host_wdata = 32'h0000_6666;
            #1;
            chk("boot_we",    rf_we,     1);
            chk("boot_waddr", rf_waddr,  i);
            chk("boot_wdata", rf_wdata,  0);
            chk("boot_stall", stall_req, 1);
            chk("boot_busy",  busy,      1);
            if (i == 11) chk("boot_wr_drop", wr_drop, 1);
            if (i == 12) chk("boot_no_ack", host_ack, 0);
            next_cycle();
        end
        pipe_we  = 1'b0;
        host_req = 1'b0;
        #1;
        chk("idle_busy",    busy,      0);
        chk("idle_stall",   stall_req, 0);
        chk("idle_rf_we",   rf_we,     0);
        chk("idle_wr_drop", wr_drop,   1);

        // ---- host write in IDLE ----
        next_cycle();
        host_req   = 1'b1;
        host_waddr = 5'd5;
        host_wdata = 32'hDEAD_BEEF;
        #1;
        chk("host_we",    rf_we,    1);
        chk("host_waddr", rf_waddr, 5);
        chk("host_wdata", rf_wdata, 32'hDEAD_BEEF);
        chk("host_ack",   host_ack, 1);
        next_cycle();
        host_req = 1'b0;
        #1;
        chk("host_ack_off", host_ack, 0);

        // ---- pipe write passes through ----
        next_cycle();
        pipe_we    = 1'b1;
        pipe_waddr = 5'd9;
        pipe_wdata = 32'h1122_3344;
        #1;
        chk("pipe_we",    rf_we,    1);
        chk("pipe_waddr", rf_waddr, 9);
        chk("pipe_wdata", rf_wdata, 32'h1122_3344);
        chk("pipe_noack", host_ack, 0);

        // ---- host starved by pipe: stall from cycle 5, saturating ----
        next_cycle();
        host_req   = 1'b1;
        host_waddr = 5'd3;
        host_wdata = 32'h1234_5678;
        pipe_waddr = 5'd4;
        pipe_wdata = 32'h0000_0044;
        for (int c = 1; c <= 10; c++) begin
            #1;
            chk("starve_stall", stall_req, (c >= 5) ? 1 : 0);
            chk("starve_waddr", rf_waddr,  4);
            chk("starve_ack",   host_ack,  0);
            next_cycle();
        end
        pipe_we = 1'b0;
        #1;
        chk("starve_ack_now", host_ack,  1);
        chk("starve_waddr3",  rf_waddr,  3);
        chk("starve_wdata",   rf_wdata,  32'h1234_5678);
        chk("starve_stall_k", stall_req, 1);
        next_cycle();
        host_req = 1'b0;
        #1;
        chk("starve_stall_off", stall_req, 0);

        // ---- host write to r0: ack without write ----
        next_cycle();
        host_req   = 1'b1;
        host_waddr = 5'd0;
        host_wdata = 32'h0000_0055;
        #1;
        chk("r0_ack", host_ack, 1);
        chk("r0_we",  rf_we,    0);
        next_cycle();
        host_req = 1'b0;

`ifdef RF_DUMP_EN
        // ---- dump all registers, stalling the consumer at idx 3 ----
        next_cycle();
        dump_start = 1'b1;
        next_cycle();
        dump_start = 1'b0;
        #1;
        for (int k = 0; k < 32; k++) begin
            for (int t = 0; t < 10; t++) begin
                if (dump_valid) break;
                @(posedge clk);
                #2;
            end
            chk("dump_valid", dump_valid, 1);
            chk("dump_addr",  dump_addr,  k);
            chk("dump_data",  dump_data,  exp_rf[k]);
            chk("dump_busy",  busy,       1);
            if (k == 3) begin
                for (int t = 0; t < 10; t++) begin
                    @(posedge clk);
                    #2;
                    chk("hold_valid", dump_valid, 1);
                    chk("hold_addr",  dump_addr,  3);
                    chk("hold_data",  dump_data,  32'h1234_5678);
                end
            end
            dump_ready = 1'b1;
            @(posedge clk);
            #1;
            dump_ready = 1'b0;
            #1;
        end
        chk("dump_done_valid", dump_valid, 0);
        chk("dump_done_busy",  busy,       0);
`endif

        // ---- clr_start (wins over dump_start), clr_start ignored mid-clear ----
        next_cycle();
        clr_start = 1'b1;
`ifdef RF_DUMP_EN
        dump_start = 1'b1;
`endif
        next_cycle();
        clr_start = 1'b0;
`ifdef RF_DUMP_EN
        dump_start = 1'b0;
`endif
        clear_cycles(1);
        chk("clr_wr_drop_sticky", wr_drop, 1);

        // ---- reset mid-clear abandons it and clears wr_drop ----
        next_cycle();
        clr_start = 1'b1;
        next_cycle();
        clr_start = 1'b0;
        repeat (3) next_cycle();
        rst = 1'b0;
        #1;
        chk("midrst_busy",    busy,      0);
        chk("midrst_we",      rf_we,     0);
        chk("midrst_stall",   stall_req, 0);
        chk("midrst_wr_drop", wr_drop,   0);
        next_cycle();
        rst = 1'b1;
        next_cycle();
        clear_cycles(1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
